// File: rtl/genesis_pad_pkg.sv
// Shared types and index constants for the Genesis/SMS multi-port pad reader.
// Button indices match the decoded word layout {Z,Y,X,M,S,C,B,A,U,D,L,R}.
package genesis_pad_pkg;

  typedef enum logic [1:0] {
    PAD_SMS = 2'b00,
    PAD_3B  = 2'b01,
    PAD_6B  = 2'b10
  } pad_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_t;

  localparam int NUM_PHASES = 8;

  localparam int BTN_R = 0;
  localparam int BTN_L = 1;
  localparam int BTN_D = 2;
  localparam int BTN_U = 3;
  localparam int BTN_A = 4;
  localparam int BTN_B = 5;
  localparam int BTN_C = 6;
  localparam int BTN_S = 7;
  localparam int BTN_M = 8;
  localparam int BTN_X = 9;
  localparam int BTN_Y = 10;
  localparam int BTN_Z = 11;

  // Raw DB9 pin positions within a port's 6-bit group
  localparam int PIN_R_M  = 0;
  localparam int PIN_L_X  = 1;
  localparam int PIN_D_Y  = 2;
  localparam int PIN_U_Z  = 3;
  localparam int PIN_B_A  = 4;
  localparam int PIN_C_ST = 5;

endpackage

// File: rtl/genesis_pad_decode.sv
// Per-port pin synchronizer, phase sample registers, pad type detection and
// button decode; the decoded word and type update only on a frame commit.
module genesis_pad_decode
  import genesis_pad_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [5:0]  pins,
  input  logic        sample_en,
  input  logic [2:0]  phase,
  input  logic        commit,
  output logic [11:0] decoded,
  output logic [1:0]  pad_type,
  output logic        changed
);

  logic [5:0]  pins_meta;
  logic [5:0]  pins_sync;
  logic [5:0]  s0;
  logic [3:0]  s1;   // {St, A, L, R} raw; L/R read low on Genesis pads with TH low
  logic [3:0]  s5;
  logic [3:0]  s6;
  pad_type_t   type_nxt;
  logic [11:0] dec_nxt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pins_meta <= '1;
      pins_sync <= '1;
    end else begin
      pins_meta <= pins;
      pins_sync <= pins_meta;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      s0 <= '1;
      s1 <= '1;
      s5 <= '1;
      s6 <= '1;
    end else if (sample_en) begin
      case (phase)
        3'd0: s0 <= pins_sync;
        3'd1: s1 <= {pins_sync[PIN_C_ST], pins_sync[PIN_B_A], pins_sync[PIN_L_X], pins_sync[PIN_R_M]};
        3'd5: s5 <= pins_sync[3:0];
        3'd6: s6 <= pins_sync[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    dec_nxt = '0;
    if (s1[1:0] != 2'b00)
      type_nxt = PAD_SMS;
    else if (s5 == 4'b0000)
      type_nxt = PAD_6B;
    else
      type_nxt = PAD_3B;

    dec_nxt[BTN_C] = ~s0[PIN_C_ST];
    dec_nxt[BTN_B] = ~s0[PIN_B_A];
    dec_nxt[BTN_U] = ~s0[PIN_U_Z];
    dec_nxt[BTN_D] = ~s0[PIN_D_Y];
    dec_nxt[BTN_L] = ~s0[PIN_L_X];
    dec_nxt[BTN_R] = ~s0[PIN_R_M];
    if (type_nxt != PAD_SMS) begin
      dec_nxt[BTN_S] = ~s1[3];
      dec_nxt[BTN_A] = ~s1[2];
    end
    if (type_nxt == PAD_6B) begin
      dec_nxt[BTN_Z] = ~s6[PIN_U_Z];
      dec_nxt[BTN_Y] = ~s6[PIN_D_Y];
      dec_nxt[BTN_X] = ~s6[PIN_L_X];
      dec_nxt[BTN_M] = ~s6[PIN_R_M];
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      decoded  <= '0;
      pad_type <= PAD_SMS;
      changed  <= 1'b0;
    end else if (commit) begin
      decoded  <= dec_nxt;
      pad_type <= type_nxt;
      changed  <= (dec_nxt != decoded);
    end
  end

endmodule

// File: rtl/genesis_multipad_reader.sv
// Genesis/SMS controller reader: polls all ports in parallel with an 8-phase
// TH sequence once per poll period and commits decoded frames with a strobe.
//
// state    | meaning
// ST_IDLE  | select high, waiting for poll counter wrap
// ST_PHASE | driving TH phases 0..7, sampling pins at each phase end
// ST_DONE  | one cycle: commit all ports, raise frame strobe
module genesis_multipad_reader
  import genesis_pad_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int SEL_PHASE_CYC = 500,
  parameter int POLL_CYC      = 833333,
  parameter int TIMEOUT_CYC   = 75000
)(
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [6*NUM_PADS-1:0]   iGENPAD,
  output logic [NUM_PADS-1:0]     oGENPAD_SELECT,
  output logic [12*NUM_PADS-1:0]  oGENPAD_DECODED,
  output logic [2*NUM_PADS-1:0]   oPAD_TYPE,
  output logic                    oVALID,
  output logic [NUM_PADS-1:0]     oCHANGED
);

  localparam int PW = $clog2(POLL_CYC);
  localparam int CW = $clog2(SEL_PHASE_CYC);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(SEL_PHASE_CYC - 1);

  generate
    if (!(POLL_CYC > 8*SEL_PHASE_CYC + TIMEOUT_CYC + 2) || SEL_PHASE_CYC < 4 ||
        NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_cfg
      $error("genesis_multipad_reader: inconsistent timing or port-count parameters");
    end
  endgenerate

  fsm_state_t    state;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    phase;
  logic          sel;
  logic          valid;
  logic          sample_en;
  logic          commit;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      poll_cnt <= '0;
    else if (poll_cnt == POLL_LAST)
      poll_cnt <= '0;
    else
      poll_cnt <= poll_cnt + PW'(1);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= ST_IDLE;
      phase   <= '0;
      cyc_cnt <= '0;
      sel     <= 1'b1;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            state   <= ST_PHASE;
            phase   <= '0;
            cyc_cnt <= '0;
            sel     <= 1'b1;
          end
        end
        ST_PHASE: begin
          if (cyc_cnt == PHASE_LAST) begin
            cyc_cnt <= '0;
            if (phase == 3'(NUM_PHASES - 1)) begin
              state <= ST_DONE;
              sel   <= 1'b1;
            end else begin
              phase <= phase + 3'd1;
              sel   <= phase[0];  // next phase p+1 drives ~(p+1)[0]
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          valid <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sample_en      = (state == ST_PHASE) && (cyc_cnt == PHASE_LAST);
  assign commit         = (state == ST_DONE);
  assign oGENPAD_SELECT = {NUM_PADS{sel}};
  assign oVALID         = valid;

  generate
    for (genvar i = 0; i < NUM_PADS; i++) begin : g_port
      genesis_pad_decode u_decode (
        .clk_sys   (iCLK),
        .rst       (iRST),
        .pins      (iGENPAD[6*i +: 6]),
        .sample_en (sample_en),
        .phase     (phase),
        .commit    (commit),
        .decoded   (oGENPAD_DECODED[12*i +: 12]),
        .pad_type  (oPAD_TYPE[2*i +: 2]),
        .changed   (oCHANGED[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_genesis_multipad_reader.sv
// Bench for genesis_multipad_reader: behavioural SMS/3-button/6-button pad
// models react to the select line; expected frames come from held buttons.
module tb_genesis_multipad_reader;
  localparam int NP   = 2;
  localparam int SEL  = 8;
  localparam int TMO  = 40;
  localparam int POLL = 120;

  logic              clk = 1'b0;
  logic              rst;
  logic [6*NP-1:0]   genpad;
  logic [NP-1:0]     sel;
  logic [12*NP-1:0]  dec;
  logic [2*NP-1:0]   ptype;
  logic              valid;
  logic [NP-1:0]     changed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          pad_kind [NP];   // 0 SMS, 1 3-button, 2 6-button
  logic [11:0] pad_btn  [NP];   // held buttons, decoded-word layout
  logic [11:0] prev_exp [NP];

  int   fall_cnt = 0;
  int   high_cnt = 0;
  logic sel_q    = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genesis_multipad_reader #(
    .NUM_PADS(NP), .SEL_PHASE_CYC(SEL), .POLL_CYC(POLL), .TIMEOUT_CYC(TMO)
  ) dut (
    .iCLK(clk), .iRST(rst), .iGENPAD(genpad), .oGENPAD_SELECT(sel),
    .oGENPAD_DECODED(dec), .oPAD_TYPE(ptype), .oVALID(valid), .oCHANGED(changed)
  );

  // 6-button pad internal state: counts TH falling edges, clears after TH idles high
  always @(posedge clk) begin
    sel_q <= sel[0];
    if (sel_q && !sel[0]) begin
      fall_cnt <= fall_cnt + 1;
      high_cnt <= 0;
    end else if (sel[0]) begin
      high_cnt <= high_cnt + 1;
      if (high_cnt >= TMO - 1) fall_cnt <= 0;
    end
  end

  function automatic logic [5:0] pad_pins(int kind, logic [11:0] b, logic s, int n);
    logic [5:0] r;
    if (kind == 0 || (s && !(kind == 2 && n == 3)))
      r = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    else if (s)
      r = ~{b[6], b[5], b[11], b[10], b[9], b[8]};
    else if (kind == 2 && n == 3)
      r = {~b[7], ~b[4], 4'b0000};
    else if (kind == 2 && n == 4)
      r = {~b[7], ~b[4], 4'b1111};
    else
      r = {~b[7], ~b[4], ~b[3], ~b[2], 2'b00};
    return r;
  endfunction

  always_comb begin
    genpad = '1;
    for (int i = 0; i < NP; i++)
      genpad[6*i +: 6] = pad_pins(pad_kind[i], pad_btn[i], sel[0], fall_cnt);
  end

  // What a pad of each kind can report
  function automatic logic [11:0] exp_dec(int kind, logic [11:0] b);
    case (kind)
      0:       return b & 12'h06F;
      1:       return b & 12'h0FF;
      default: return b;
    endcase
  endfunction

  // No d-pad can press opposite directions together
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[2] = 1'b0;
    return b;
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_strobe: no oVALID within 400 cycles, required one");
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NP; i++) prev_exp[i] = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NP; i++) begin
      pad_kind[i] = 0;
      pad_btn[i]  = '0;
      prev_exp[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sel !== 2'b11)  begin bad++; $display("FAIL reset_select: got %b want 11", sel); end
    total++; if (dec !== '0)     begin bad++; $display("FAIL reset_decoded: got %h want 0", dec); end
    total++; if (ptype !== '0)   begin bad++; $display("FAIL reset_type: got %b want 0", ptype); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (changed !== '0) begin bad++; $display("FAIL reset_changed: got %b want 0", changed); end
    rst = 1'b0;
  endtask

  task automatic test_sms();
    bit ok;
    int lows;
    pad_kind[0] = 0; pad_btn[0] = 12'h041;
    pad_kind[1] = 0; pad_btn[1] = 12'h000;
    wait_valid(ok);
    total++; if (dec[11:0] !== 12'h041) begin bad++; $display("FAIL sms_decoded: got %h want 041", dec[11:0]); end
    total++; if (ptype[1:0] !== 2'b00)  begin bad++; $display("FAIL sms_type: got %b want 00", ptype[1:0]); end
    for (int i = 0; i < NP; i++) prev_exp[i] = exp_dec(pad_kind[i], pad_btn[i]);
    lows = 0;
    repeat (TMO) begin
      @(negedge clk);
      if (sel !== 2'b11) lows++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL sms_idle_select: low cycles %0d want 0", lows); end
  endtask

  task automatic test_3b();
    bit ok;
    pad_kind[0] = 1; pad_btn[0] = 12'h098;
    wait_valid(ok);
    total++; if (dec[11:0] !== 12'h098) begin bad++; $display("FAIL 3b_decoded: got %h want 098", dec[11:0]); end
    total++; if (ptype[1:0] !== 2'b01)  begin bad++; $display("FAIL 3b_type: got %b want 01", ptype[1:0]); end
    total++; if (changed[0] !== 1'b1)   begin bad++; $display("FAIL 3b_changed: got %b want 1", changed[0]); end
    for (int i = 0; i < NP; i++) prev_exp[i] = exp_dec(pad_kind[i], pad_btn[i]);
  endtask

  task automatic test_6b();
    bit ok;
    pad_kind[0] = 2; pad_btn[0] = 12'h920;
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      total++; if (dec[11:0] !== 12'h920) begin bad++; $display("FAIL 6b_decoded poll%0d: got %h want 920", k, dec[11:0]); end
      total++; if (ptype[1:0] !== 2'b10)  begin bad++; $display("FAIL 6b_type poll%0d: got %b want 10", k, ptype[1:0]); end
      total++; if (changed[0] !== (k == 0)) begin bad++; $display("FAIL 6b_changed poll%0d: got %b want %0d", k, changed[0], k == 0); end
    end
    for (int i = 0; i < NP; i++) prev_exp[i] = exp_dec(pad_kind[i], pad_btn[i]);
  endtask

  task automatic test_two_port();
    bit ok;
    pad_kind[0] = 2; pad_btn[0] = 12'h400;
    pad_kind[1] = 0; pad_btn[1] = 12'h000;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      total++; if (dec !== {12'h000, 12'h400}) begin bad++; $display("FAIL two_port_decoded poll%0d: got %h want 000400", k, dec); end
      total++; if (ptype !== 4'b0010) begin bad++; $display("FAIL two_port_type poll%0d: got %b want 0010", k, ptype); end
      total++; if (changed !== ((k == 0) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL two_port_changed poll%0d: got %b want %b", k, changed, (k == 0) ? 2'b01 : 2'b00); end
    end
    for (int i = 0; i < NP; i++) prev_exp[i] = exp_dec(pad_kind[i], pad_btn[i]);
  endtask

  task automatic test_timing();
    bit ok;
    int t0, period, toggles, bad_gap, split, last_t;
    logic last_sel;
    wait_valid(ok);
    t0 = cyc; last_sel = sel[0]; last_t = -1;
    toggles = 0; bad_gap = 0; split = 0; period = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sel[1] !== sel[0]) split++;
      if (valid) begin
        period = cyc - t0;
        break;
      end
      if (sel[0] !== last_sel) begin
        if (last_t >= 0 && (cyc - last_t) != SEL) bad_gap++;
        last_t = cyc;
        last_sel = sel[0];
        toggles++;
      end
    end
    total++; if (period != POLL) begin bad++; $display("FAIL valid_period: got %0d want %0d", period, POLL); end
    total++; if (toggles != 8)   begin bad++; $display("FAIL select_toggles: got %0d want 8", toggles); end
    total++; if (bad_gap != 0)   begin bad++; $display("FAIL select_phase_len: %0d gaps not %0d cycles", bad_gap, SEL); end
    total++; if (split != 0)     begin bad++; $display("FAIL select_bits_equal: %0d cycles differ, want 0", split); end
    for (int i = 0; i < NP; i++) prev_exp[i] = exp_dec(pad_kind[i], pad_btn[i]);
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] e;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NP; i++) begin
        pad_kind[i] = int'($urandom_range(0, 2));
        pad_btn[i]  = rand_btn();
      end
      wait_valid(ok);
      for (int i = 0; i < NP; i++) begin
        e = exp_dec(pad_kind[i], pad_btn[i]);
        total++; if (dec[12*i +: 12] !== e) begin bad++; $display("FAIL rand_decoded it%0d port%0d: got %h want %h", it, i, dec[12*i +: 12], e); end
        total++; if (ptype[2*i +: 2] !== 2'(pad_kind[i])) begin bad++; $display("FAIL rand_type it%0d port%0d: got %b want %0d", it, i, ptype[2*i +: 2], pad_kind[i]); end
        total++; if (changed[i] !== (e != prev_exp[i])) begin bad++; $display("FAIL rand_changed it%0d port%0d: got %b want %b", it, i, changed[i], e != prev_exp[i]); end
        prev_exp[i] = e;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, fell;
    int strobes;
    pad_kind[0] = 1; pad_btn[0] = rand_btn();
    pad_kind[1] = 2; pad_btn[1] = rand_btn();
    fell = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel[0] === 1'b0) begin fell = 1'b1; break; end
    end
    total++; if (!fell) begin bad++; $display("FAIL midrst_seq_start: no select low within 200 cycles"); end
    repeat (3*SEL + 2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (sel !== 2'b11) begin bad++; $display("FAIL midrst_select: got %b want 11", sel); end
    total++; if (dec !== '0 || ptype !== '0) begin bad++; $display("FAIL midrst_outputs: dec %h type %b want 0", dec, ptype); end
    total++; if (valid !== 1'b0 || changed !== '0) begin bad++; $display("FAIL midrst_flags: valid %b changed %b want 0", valid, changed); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NP; i++) prev_exp[i] = '0;
    strobes = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid === 1'b1) strobes++;
    end
    total++; if (strobes != 0) begin bad++; $display("FAIL midrst_no_frame: got %0d strobes want 0", strobes); end
    wait_valid(ok);
    total++; if (dec !== {exp_dec(2, pad_btn[1]), exp_dec(1, pad_btn[0])}) begin bad++; $display("FAIL midrst_decoded: got %h want %h", dec, {exp_dec(2, pad_btn[1]), exp_dec(1, pad_btn[0])}); end
    total++; if (ptype !== 4'b1001) begin bad++; $display("FAIL midrst_type: got %b want 1001", ptype); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_sms();
    test_3b();
    test_6b();
    test_two_port();
    test_timing();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
